peripheral_ahb4_master: RTL and testbench
=========================================

Name: peripheral_ahb4_master

Overview:
- Single-transfer AHB4 AHB-Lite master (initiator) for the MPSoC peripheral BFM library.
- Converts a valid/ready command interface into AHB-Lite SINGLE transfers, and returns read data and error status on a valid/ready response interface.
- Used to drive AHB4 slaves such as the timer peripheral from testbench tasks or simple controllers.
- One transfer outstanding at a time; no burst or pipelined overlap.

Parameters:
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width; only 32 and 64 are legal.
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data access, privileged).

Ports:
- HRESETn  input  1  asynchronous active-low reset.
- HCLK  input  1  clock; all logic on the rising edge.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  HADDR_SIZE  byte address.
- cmd_size  input  3  HSIZE encoding; only BYTE/HWORD/WORD are legal, plus DWORD if HDATA_SIZE=64.
- cmd_wdata  input  HDATA_SIZE  write data, already lane-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  HDATA_SIZE  read data; 0 for writes.
- rsp_err  output  1  1 = bus ERROR or rejected command.
- HSEL  output  1  slave select.
- HADDR  output  HADDR_SIZE  address.
- HWDATA  output  HDATA_SIZE  write data.
- HRDATA  input  HDATA_SIZE  read data.
- HWRITE  output  1  transfer direction.
- HSIZE  output  3  transfer size.
- HBURST  output  3  burst type; always SINGLE (3'b000).
- HPROT  output  4  protection; always HPROT_VAL.
- HTRANS  output  2  transfer type; IDLE or NONSEQ only.
- HMASTLOCK  output  1  lock; always 0.
- HREADY  input  1  bus ready (transfer done).
- HRESP  input  1  slave response; 0=OKAY, 1=ERROR.

Behaviour:
- Clock and reset: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: HTRANS=IDLE, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, cmd_ready=0 while HRESETn low, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- FSM states: IDLE, ADDR, DATA, RSP.
- IDLE:
  - cmd_ready=1; HTRANS=IDLE; HSEL=0.
  - On a cmd_valid handshake, capture the command into registers.
  - Misaligned command (cmd_addr not a multiple of 2^cmd_size) or illegal size: go to RSP with rsp_err=1, rsp_rdata=0, and no bus activity.
  - Otherwise go to ADDR.
- ADDR:
  - Drive HTRANS=NONSEQ, HSEL=1, and the registered HADDR/HWRITE/HSIZE.
  - Hold all address-phase signals stable while HREADY=0.
  - On a rising edge with HREADY=1, go to DATA.
- DATA:
  - HTRANS=IDLE, HSEL=0; HWDATA = registered write data (writes only), held until HREADY=1.
  - On an edge with HREADY=1: capture rsp_rdata = HRDATA for reads (0 for writes) and rsp_err = HRESP; go to RSP.
  - ERROR is two-cycle: in the first cycle (HRESP=1, HREADY=0) HTRANS is already IDLE, so no cancel is needed. Capture happens in the second cycle.
- RSP:
  - rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE.
  - cmd_ready=0 outside IDLE.
- Latency:
  - Command accepted at edge N: NONSEQ driven in cycle N+1.
  - With zero wait states, rsp_valid asserts in cycle N+3.
  - Each HREADY=0 cycle in the address or data phase adds one cycle.
- Throughput: one command per ≥4 cycles; a new cmd can only be accepted the cycle after the response handshake.
- Reset mid-transfer: all state returns to IDLE immediately and asynchronously. Any pending response is discarded, with no rsp_valid after reset release.
- HADDR, HWRITE, HSIZE keep their last value when idle; only HTRANS/HSEL indicate activity.

Test Plan:
- Zero-wait write: cmd write addr=0x0, size=WORD, wdata=0x0000_0010, slave HREADY=1 → NONSEQ for exactly one cycle; HWDATA=0x10 in the next cycle; rsp_valid 3 cycles after accept with rsp_err=0.
- Read with wait states: read addr=0x14; slave holds HREADY=0 for 2 data-phase cycles, then returns HRDATA=0xDEAD_BEEF → HWDATA/HADDR stable throughout; rsp_rdata=0xDEADBEEF, rsp_err=0, latency 5 cycles.
- ERROR response: write addr=0x40; slave returns HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 → HTRANS=IDLE both cycles; rsp_err=1.
- Misaligned command: read addr=0x2, size=WORD → no NONSEQ ever driven; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid → rsp fields stable, cmd_ready=0, no new bus transfer; after rsp_ready=1, cmd_ready=1 the next cycle.
- Reset mid-transfer: assert HRESETn=0 during the DATA phase of a read → outputs go to reset values asynchronously; after release, no rsp_valid, and a subsequent write completes normally.

Source files
------------

// File: rtl/peripheral_ahb4_master_if.sv
// AHB-Lite bus bundle between the single-transfer master and an AHB4 slave.
// Parameters: HADDR_SIZE (address width), HDATA_SIZE (data width, 32 or 64).
// Modports:
//   master - drives HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK,
//            samples HRDATA/HREADY/HRESP.
//   slave  - the mirror image.
interface peripheral_ahb4_master_if #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
);
   logic                  HSEL;
   logic [HADDR_SIZE-1:0] HADDR;
   logic [HDATA_SIZE-1:0] HWDATA;
   logic [HDATA_SIZE-1:0] HRDATA;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [1:0]            HTRANS;
   logic                  HMASTLOCK;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/peripheral_ahb4_master.sv
// Single-transfer AHB-Lite master: turns one valid/ready command into one
// SINGLE NONSEQ transfer and returns read data / error on a valid/ready
// response channel. One transfer outstanding at a time.
// Ports:
//   HRESETn, HCLK           - async active-low reset, rising-edge clock
//   cmd_valid/cmd_ready     - command handshake; cmd_write/addr/size/wdata payload
//   rsp_valid/rsp_ready     - response handshake; rsp_rdata/rsp_err payload
//   ahb                     - AHB-Lite bus (master modport)
module peripheral_ahb4_master #(
   parameter int          HADDR_SIZE = 32,
   parameter int          HDATA_SIZE = 32,
   parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
   input  logic                  HRESETn,
   input  logic                  HCLK,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [HADDR_SIZE-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic [HDATA_SIZE-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [HDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   peripheral_ahb4_master_if.master ahb
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic       DWORD_OK      = (HDATA_SIZE == 64);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   state_t                state_r, next_state_s;
   logic                  accept_s, cmd_ok_s;
   logic                  cmd_ready_r, rsp_valid_r, rsp_err_r;
   logic [HDATA_SIZE-1:0] rsp_rdata_r, wdata_r, hwdata_r;
   logic [HADDR_SIZE-1:0] haddr_r;
   logic                  hwrite_r, hsel_r;
   logic [2:0]            hsize_r;
   logic [1:0]            htrans_r;

   // A command is legal when its size fits the bus and the address is size-aligned.
   function automatic logic cmd_legal(input logic [2:0] addr_lo, input logic [2:0] size);
      logic ok;
      case (size)
         3'd0:    ok = 1'b1;
         3'd1:    ok = (addr_lo[0] == 1'b0);
         3'd2:    ok = (addr_lo[1:0] == 2'b00);
         3'd3:    ok = DWORD_OK && (addr_lo == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Next-state logic of the transfer sequencer.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      cmd_ok_s     = cmd_legal(cmd_addr[2:0], cmd_size);
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               accept_s = 1'b1;
               // Rejected commands skip the bus and report straight away.
               if (cmd_ok_s) begin
                  next_state_s = ST_ADDR;
               end else begin
                  next_state_s = ST_RSP;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (ahb.HREADY) begin
               next_state_s = ST_DATA;
            end else begin
               next_state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (ahb.HREADY) begin
               next_state_s = ST_RSP;
            end else begin
               next_state_s = ST_DATA;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RSP;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register and registered control outputs derived from the next state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         htrans_r    <= HTRANS_IDLE;
         hsel_r      <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         cmd_ready_r <= (next_state_s == ST_IDLE);
         rsp_valid_r <= (next_state_s == ST_RSP);
         htrans_r    <= (next_state_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
         hsel_r      <= (next_state_s == ST_ADDR);
      end
   end

   // Command capture, write-data phase and response capture.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr_r     <= {HADDR_SIZE{1'b0}};
         hwrite_r    <= 1'b0;
         hsize_r     <= 3'b000;
         wdata_r     <= {HDATA_SIZE{1'b0}};
         hwdata_r    <= {HDATA_SIZE{1'b0}};
         rsp_rdata_r <= {HDATA_SIZE{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         // Address-phase registers only change for commands that reach the bus.
         if (accept_s && cmd_ok_s) begin
            haddr_r  <= cmd_addr;
            hwrite_r <= cmd_write;
            hsize_r  <= cmd_size;
            wdata_r  <= cmd_wdata;
         end
         // HWDATA moves into the data phase one cycle after the address is taken.
         if ((state_r == ST_ADDR) && ahb.HREADY && hwrite_r) begin
            hwdata_r <= wdata_r;
         end
         if (accept_s && !cmd_ok_s) begin
            rsp_rdata_r <= {HDATA_SIZE{1'b0}};
            rsp_err_r   <= 1'b1;
         end else if ((state_r == ST_DATA) && ahb.HREADY) begin
            rsp_rdata_r <= hwrite_r ? {HDATA_SIZE{1'b0}} : ahb.HRDATA;
            rsp_err_r   <= ahb.HRESP;
         end
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_rdata     = rsp_rdata_r;
   assign rsp_err       = rsp_err_r;
   assign ahb.HSEL      = hsel_r;
   assign ahb.HADDR     = haddr_r;
   assign ahb.HWDATA    = hwdata_r;
   assign ahb.HWRITE    = hwrite_r;
   assign ahb.HSIZE     = hsize_r;
   assign ahb.HBURST    = 3'b000;
   assign ahb.HPROT     = HPROT_VAL;
   assign ahb.HTRANS    = htrans_r;
   assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_ahb4_master.sv
// Directed bench for peripheral_ahb4_master: the bench plays the AHB slave
// cycle by cycle and checks bus and response outputs against hand-derived values.
module tb_peripheral_ahb4_master;

   logic        HRESETn;
   logic        HCLK;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int vec_cnt;
   int err_cnt;
   int nonseq_cnt;
   int n0;

   peripheral_ahb4_master_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

   peripheral_ahb4_master #(.HADDR_SIZE(32), .HDATA_SIZE(32), .HPROT_VAL(4'b0011)) dut (
      .HRESETn   (HRESETn),
      .HCLK      (HCLK),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ahb       (bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Count address phases actually put on the bus.
   always @(negedge HCLK) begin
      if (bus.HTRANS == 2'b10) nonseq_cnt <= nonseq_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Present one command and return one cycle after the accepting edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
      for (int i = 0; i < 20 && !cmd_ready; i++) step();
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_size  = size;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   // Consume the pending response and confirm the master is ready again.
   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("ready_again", cmd_ready, 1);
   endtask

   initial begin
      vec_cnt = 0; err_cnt = 0; nonseq_cnt = 0;
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
      cmd_size = 3'd0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;

      // Reset values
      #2;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_htrans", bus.HTRANS, 2'b00);
      chk("rst_hsel", bus.HSEL, 0);
      chk("rst_haddr", bus.HADDR, 32'h0);
      chk("rst_hwdata", bus.HWDATA, 32'h0);
      chk("hburst", bus.HBURST, 3'b000);
      chk("hprot", bus.HPROT, 4'b0011);
      chk("hmastlock", bus.HMASTLOCK, 0);
      #20 HRESETn = 1'b1;
      step();
      chk("idle_cmd_ready", cmd_ready, 1);

      // Zero-wait word write
      n0 = nonseq_cnt;
      issue(1'b1, 32'h0, 3'd2, 32'h0000_0010);
      chk("w_htrans", bus.HTRANS, 2'b10);
      chk("w_hsel", bus.HSEL, 1);
      chk("w_haddr", bus.HADDR, 32'h0);
      chk("w_hwrite", bus.HWRITE, 1);
      chk("w_hsize", bus.HSIZE, 3'd2);
      chk("w_cmd_ready", cmd_ready, 0);
      step();
      chk("w_dp_htrans", bus.HTRANS, 2'b00);
      chk("w_hwdata", bus.HWDATA, 32'h10);
      chk("w_rsp_early", rsp_valid, 0);
      step();
      chk("w_rsp_valid", rsp_valid, 1);
      chk("w_rsp_err", rsp_err, 0);
      chk("w_rsp_rdata", rsp_rdata, 32'h0);
      chk("w_nonseq_cnt", nonseq_cnt - n0, 1);
      finish_rsp();

      // Read with two data-phase wait states
      issue(1'b0, 32'h14, 3'd2, 32'hFFFF_FFFF);
      chk("r_htrans", bus.HTRANS, 2'b10);
      chk("r_hwrite", bus.HWRITE, 0);
      step();
      bus.HREADY = 1'b0; bus.HRDATA = 32'h1234_5678;
      for (int i = 0; i < 2; i++) begin
         chk("r_haddr_hold", bus.HADDR, 32'h14);
         chk("r_hwdata_hold", bus.HWDATA, 32'h10);
         chk("r_dp_htrans", bus.HTRANS, 2'b00);
         chk("r_rsp_early", rsp_valid, 0);
         step();
      end
      bus.HREADY = 1'b1; bus.HRDATA = 32'hDEAD_BEEF;
      chk("r_rsp_early2", rsp_valid, 0);
      step();
      bus.HRDATA = 32'h0;
      chk("r_rsp_valid", rsp_valid, 1);
      chk("r_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("r_err", rsp_err, 0);
      finish_rsp();

      // Two-cycle ERROR response on a write
      issue(1'b1, 32'h40, 3'd2, 32'hA5A5_A5A5);
      chk("e_htrans", bus.HTRANS, 2'b10);
      step();
      bus.HRESP = 1'b1; bus.HREADY = 1'b0;
      chk("e_htrans_c1", bus.HTRANS, 2'b00);
      step();
      bus.HREADY = 1'b1;
      chk("e_htrans_c2", bus.HTRANS, 2'b00);
      chk("e_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
      step();
      bus.HRESP = 1'b0;
      chk("e_rsp_valid", rsp_valid, 1);
      chk("e_rsp_err", rsp_err, 1);
      chk("e_rsp_rdata", rsp_rdata, 32'h0);
      finish_rsp();

      // Misaligned word read: rejected without bus activity
      n0 = nonseq_cnt;
      issue(1'b0, 32'h2, 3'd2, 32'h0);
      chk("m_htrans", bus.HTRANS, 2'b00);
      chk("m_hsel", bus.HSEL, 0);
      chk("m_rsp_valid", rsp_valid, 1);
      chk("m_rsp_err", rsp_err, 1);
      chk("m_rsp_rdata", rsp_rdata, 32'h0);
      chk("m_haddr_kept", bus.HADDR, 32'h40);
      finish_rsp();
      // Misaligned halfword and DWORD on a 32-bit bus
      issue(1'b0, 32'h1, 3'd1, 32'h0);
      chk("m_hw_err", rsp_err, 1);
      finish_rsp();
      issue(1'b1, 32'h8, 3'd3, 32'h0);
      chk("m_dw_err", rsp_err, 1);
      finish_rsp();
      chk("m_nonseq_cnt", nonseq_cnt - n0, 0);

      // Byte read at an odd address is legal
      issue(1'b0, 32'h3, 3'd0, 32'h0);
      chk("b_htrans", bus.HTRANS, 2'b10);
      chk("b_hsize", bus.HSIZE, 3'd0);
      step();
      bus.HRDATA = 32'h7700_0000;
      step();
      bus.HRDATA = 32'h0;
      chk("b_rsp_valid", rsp_valid, 1);
      chk("b_rdata", rsp_rdata, 32'h7700_0000);
      chk("b_err", rsp_err, 0);
      finish_rsp();

      // Response backpressure with a new command already waiting
      n0 = nonseq_cnt;
      issue(1'b1, 32'h8, 3'd2, 32'h0000_5555);
      step();
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      cmd_write = 1'b0; cmd_addr = 32'h4; cmd_size = 3'd2; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_err", rsp_err, 0);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_htrans", bus.HTRANS, 2'b00);
      end
      cmd_valid = 1'b0;
      chk("bp_nonseq_cnt", nonseq_cnt - n0, 1);
      finish_rsp();

      // Reset asserted during the data phase of a read
      issue(1'b0, 32'h20, 3'd2, 32'h0);
      chk("x_htrans", bus.HTRANS, 2'b10);
      step();
      bus.HREADY = 1'b0;
      #2 HRESETn = 1'b0;
      #1;
      chk("x_htrans_rst", bus.HTRANS, 2'b00);
      chk("x_hsel_rst", bus.HSEL, 0);
      chk("x_haddr_rst", bus.HADDR, 32'h0);
      chk("x_hwdata_rst", bus.HWDATA, 32'h0);
      chk("x_cmd_ready_rst", cmd_ready, 0);
      chk("x_rsp_valid_rst", rsp_valid, 0);
      bus.HREADY = 1'b1;
      #4 HRESETn = 1'b1;
      n0 = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid) n0++;
      end
      chk("x_no_stale_rsp", n0, 0);
      issue(1'b1, 32'hC, 3'd1, 32'h0000_BEEF);
      chk("x2_haddr", bus.HADDR, 32'hC);
      chk("x2_hsize", bus.HSIZE, 3'd1);
      step();
      chk("x2_hwdata", bus.HWDATA, 32'h0000_BEEF);
      step();
      chk("x2_rsp_valid", rsp_valid, 1);
      chk("x2_rsp_err", rsp_err, 0);
      finish_rsp();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
